ysyx_22040632_axi_rr_arbiter: RTL and testbench
===============================================

# ysyx_22040632_axi_rr_arbiter

Parametrised N-master to 1-master AXI4 arbiter. It generalises the core's fixed two-port instruction/data arbiter to `NUM_MASTERS` requesters (icache, dcache, DMA, debug), with burst pass-through. It sits between the cache/requester layer and the AXI master bridge. It keeps one transaction outstanding at a time, holds the grant until the last R beat or the B response, and then rotates priority.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of upstream requesters, ≥1.
- `AXI_DATA_WIDTH`, 64: data width.
- `AXI_ADDR_WIDTH`, 32: address width.
- `AXI_ID_WIDTH`, 4: ID width, passed through unchanged.
- `IDX_W`, `$clog2(NUM_MASTERS)` with a minimum of 1: width of grant index.

Ports. Upstream `s_*` ports are flattened, with master k in slice k.
- **Clock and reset**
  - `clk` in 1: clock, rising edge.
  - `rrst_n` in 1: asynchronous active-low reset.
- **Upstream read address**
  - `s_ar_valid`, `s_ar_ready` in/out N.
  - `s_ar_addr` in N*AXI_ADDR_WIDTH.
  - `s_ar_id` in N*AXI_ID_WIDTH.
  - `s_ar_len` in N*8, `s_ar_size` in N*3, `s_ar_burst` in N*2.
- **Upstream read data**
  - `s_r_valid` out N, `s_r_ready` in N.
  - `s_r_data` out AXI_DATA_WIDTH, `s_r_resp` out 2, `s_r_last` out 1, `s_r_id` out AXI_ID_WIDTH. These are shared buses, qualified by `s_r_valid[k]`.
- **Upstream write address**
  - `s_aw_valid`/`s_aw_ready`, `s_aw_addr`, `s_aw_id`, `s_aw_len`, `s_aw_size`, `s_aw_burst`: same widths as the AR group.
- **Upstream write data**
  - `s_w_valid` in N, `s_w_ready` out N.
  - `s_w_data` in N*AXI_DATA_WIDTH, `s_w_strb` in N*AXI_DATA_WIDTH/8, `s_w_last` in N.
- **Upstream write response**
  - `s_b_valid` out N, `s_b_ready` in N.
  - `s_b_resp` out 2, `s_b_id` out AXI_ID_WIDTH. These are shared buses.
- **Downstream**
  - `m_ar_*`, `m_r_*`, `m_aw_*`, `m_w_*`, `m_b_*`: a single AXI4 master port with the same fields and opposite directions.
- **Status**
  - `grant_idx` out IDX_W: current grant.
  - `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP. Reset value is IDLE.
- **Request vector:** `req[k] = s_ar_valid[k] | s_aw_valid[k]`.
- **Arbitration in IDLE:**
  - If `req != 0`, select a winner g (see Configuration) and register it into `grant_idx`.
  - If `s_ar_valid[g]` is set, go to RD_ADDR; otherwise go to WR_ADDR. Reads win over writes for the same master.
- **RD_ADDR:**
  - `m_ar_*` is muxed from slice g.
  - `s_ar_ready[g] = m_ar_ready`.
  - On the `m_ar_valid & m_ar_ready` handshake, go to RD_DATA.
- **RD_DATA:**
  - `s_r_valid[g] = m_r_valid` and `m_r_ready = s_r_ready[g]`.
  - On a handshake with `m_r_last`, update the pointer and go to IDLE.
- **WR_ADDR:** the AW handshake moves the FSM to WR_DATA.
- **WR_DATA:** W beats are forwarded from slice g. A handshake with `s_w_last[g]` moves the FSM to WR_RESP.
- **WR_RESP:** a B handshake updates the pointer and moves the FSM to IDLE.
- **Non-granted ports:** every ready/valid output for a non-granted port is 0. Outputs of channels not active in the current state are 0.
- **Routing:** responses are routed by `grant_idx`, never by ID. IDs pass through unmodified.
- **Outstanding transactions:** only one transaction is outstanding. AR and AW are never both valid downstream.

## Timing
- **Reset values:** every `m_*_valid`, `m_*_ready`, `s_*_valid` and `s_*_ready` is 0. `grant_idx` is 0, `busy` is 0, and the RR pointer is 0.
- **Latency:** the upstream valid sampled in IDLE produces `m_ar_valid`/`m_aw_valid` in the next cycle. Arbitration costs 1 cycle.
- **Data path:** all data and handshakes in the ADDR/DATA/RESP states are combinational pass-throughs with zero added latency. Back-to-back bursts from the same or different masters have 1 idle cycle between them, spent in IDLE.
- **Pointer update:** on completion, `ptr <= (g == NUM_MASTERS-1) ? 0 : g+1`, so the pointer wraps.
- **Valid stability:** masters keep valid asserted until accepted, as AXI requires. Deasserting valid early is unsupported; the FSM stays in the ADDR state.
- **Simultaneous AR and AW from one master:** the read is served first. The AW remains pending and takes part in the next arbitration.
- **Single master:** with `NUM_MASTERS=1`, g is always 0 and the arbitration cycle still occurs.
- **Reset mid-burst:** the FSM returns to IDLE immediately. No further beats are forwarded, and the downstream slave must also be reset.

## Configuration
- **`YSYX_22040632_ARB_RR_EN` defined:** round-robin. The winner is the first k with `req[k]=1`, searching ptr, ptr+1, … and wrapping modulo N.
- **Undefined:** fixed priority. The lowest index with `req[k]=1` wins and the pointer is ignored, matching the previous two-port arbiter where port 0 (ifu) has the highest priority.

## Test plan
- **Reset:** assert `rrst_n=0` with all `s_ar_valid` high → all valid/ready outputs are 0 and `busy=0`. Release reset → `m_ar_valid=1` exactly 1 cycle after the first IDLE cycle, and `grant_idx=0`.
- **Read burst:** N=4, master 2 issues AR addr=0x8000_0040, len=3, id=5 → downstream sees the same fields. Four R beats are delivered only on `s_r_valid[2]` with id=5. The FSM returns to IDLE after the last beat, and the pointer is 3.
- **RR fairness (RR_EN):** all 4 masters hold AR continuously with len=0 → grant order is 0,1,2,3,0. Without the macro, the order is 0,0,0,….
- **Write:** master 1 issues AW addr=0x8000_1000, len=1, with two W beats, strb=0xFF, data 0x1111…/0x2222… → both beats are forwarded and the B response with resp=0 is routed to `s_b_valid[1]` only.
- **Same-master AR and AW:** master 0 raises AR and AW in the same cycle → the read completes first, then the write is granted in a later arbitration.
- **Backpressure:** `m_r_ready` is held low by `s_r_ready[g]=0` for 5 cycles → no beat is lost and the data order is preserved.

Source files
------------

// File: rtl/ysyx_22040632_axi_rr_arbiter.sv
// rtl/ysyx_22040632_axi_rr_arbiter.sv - N-to-1 AXI4 arbiter, one outstanding transaction, burst pass-through
// YSYX_22040632_ARB_RR_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module ysyx_22040632_axi_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rrst_n,
  input  logic [NUM_MASTERS-1:0]                     s_ar_valid,
  output logic [NUM_MASTERS-1:0]                     s_ar_ready,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]      s_ar_addr,
  input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]        s_ar_id,
  input  logic [NUM_MASTERS*8-1:0]                   s_ar_len,
  input  logic [NUM_MASTERS*3-1:0]                   s_ar_size,
  input  logic [NUM_MASTERS*2-1:0]                   s_ar_burst,
  output logic [NUM_MASTERS-1:0]                     s_r_valid,
  input  logic [NUM_MASTERS-1:0]                     s_r_ready,
  output logic [AXI_DATA_WIDTH-1:0]                  s_r_data,
  output logic [1:0]                                 s_r_resp,
  output logic                                       s_r_last,
  output logic [AXI_ID_WIDTH-1:0]                    s_r_id,
  input  logic [NUM_MASTERS-1:0]                     s_aw_valid,
  output logic [NUM_MASTERS-1:0]                     s_aw_ready,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]      s_aw_addr,
  input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]        s_aw_id,
  input  logic [NUM_MASTERS*8-1:0]                   s_aw_len,
  input  logic [NUM_MASTERS*3-1:0]                   s_aw_size,
  input  logic [NUM_MASTERS*2-1:0]                   s_aw_burst,
  input  logic [NUM_MASTERS-1:0]                     s_w_valid,
  output logic [NUM_MASTERS-1:0]                     s_w_ready,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]      s_w_data,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH/8-1:0]    s_w_strb,
  input  logic [NUM_MASTERS-1:0]                     s_w_last,
  output logic [NUM_MASTERS-1:0]                     s_b_valid,
  input  logic [NUM_MASTERS-1:0]                     s_b_ready,
  output logic [1:0]                                 s_b_resp,
  output logic [AXI_ID_WIDTH-1:0]                    s_b_id,
  output logic                                       m_ar_valid,
  input  logic                                       m_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]                  m_ar_addr,
  output logic [AXI_ID_WIDTH-1:0]                    m_ar_id,
  output logic [7:0]                                 m_ar_len,
  output logic [2:0]                                 m_ar_size,
  output logic [1:0]                                 m_ar_burst,
  input  logic                                       m_r_valid,
  output logic                                       m_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0]                  m_r_data,
  input  logic [1:0]                                 m_r_resp,
  input  logic                                       m_r_last,
  input  logic [AXI_ID_WIDTH-1:0]                    m_r_id,
  output logic                                       m_aw_valid,
  input  logic                                       m_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0]                  m_aw_addr,
  output logic [AXI_ID_WIDTH-1:0]                    m_aw_id,
  output logic [7:0]                                 m_aw_len,
  output logic [2:0]                                 m_aw_size,
  output logic [1:0]                                 m_aw_burst,
  output logic                                       m_w_valid,
  input  logic                                       m_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]                  m_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]                m_w_strb,
  output logic                                       m_w_last,
  input  logic                                       m_b_valid,
  output logic                                       m_b_ready,
  input  logic [1:0]                                 m_b_resp,
  input  logic [AXI_ID_WIDTH-1:0]                    m_b_id,
  output logic [IDX_W-1:0]                           grant_idx,
  output logic                                       busy
);

  localparam int SW = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t                     state, state_nxt;
  logic [NUM_MASTERS-1:0]     req;
  logic [IDX_W-1:0]           winner;
  logic [IDX_W-1:0]           cand;
  logic                       found;
  logic                       done;

  logic [AXI_ADDR_WIDTH-1:0]  ar_addr_a  [NUM_MASTERS];
  logic [AXI_ID_WIDTH-1:0]    ar_id_a    [NUM_MASTERS];
  logic [7:0]                 ar_len_a   [NUM_MASTERS];
  logic [2:0]                 ar_size_a  [NUM_MASTERS];
  logic [1:0]                 ar_burst_a [NUM_MASTERS];
  logic [AXI_ADDR_WIDTH-1:0]  aw_addr_a  [NUM_MASTERS];
  logic [AXI_ID_WIDTH-1:0]    aw_id_a    [NUM_MASTERS];
  logic [7:0]                 aw_len_a   [NUM_MASTERS];
  logic [2:0]                 aw_size_a  [NUM_MASTERS];
  logic [1:0]                 aw_burst_a [NUM_MASTERS];
  logic [AXI_DATA_WIDTH-1:0]  w_data_a   [NUM_MASTERS];
  logic [SW-1:0]              w_strb_a   [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign ar_addr_a[k]  = s_ar_addr[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign ar_id_a[k]    = s_ar_id[k*AXI_ID_WIDTH +: AXI_ID_WIDTH];
    assign ar_len_a[k]   = s_ar_len[k*8 +: 8];
    assign ar_size_a[k]  = s_ar_size[k*3 +: 3];
    assign ar_burst_a[k] = s_ar_burst[k*2 +: 2];
    assign aw_addr_a[k]  = s_aw_addr[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign aw_id_a[k]    = s_aw_id[k*AXI_ID_WIDTH +: AXI_ID_WIDTH];
    assign aw_len_a[k]   = s_aw_len[k*8 +: 8];
    assign aw_size_a[k]  = s_aw_size[k*3 +: 3];
    assign aw_burst_a[k] = s_aw_burst[k*2 +: 2];
    assign w_data_a[k]   = s_w_data[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign w_strb_a[k]   = s_w_strb[k*SW +: SW];
  end

  assign req = s_ar_valid | s_aw_valid;

`ifdef YSYX_22040632_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   rr_sum;

  // Search ptr, ptr+1, ... wrapping modulo NUM_MASTERS; first requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    rr_sum = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rr_sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (rr_sum >= (IDX_W+1)'(NUM_MASTERS))
        rr_sum = rr_sum - (IDX_W+1)'(NUM_MASTERS);
      cand = rr_sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n)
      ptr <= '0;
    else if (done)
      ptr <= (grant_idx == IDX_W'(NUM_MASTERS-1)) ? '0 : grant_idx + 1'b1;
  end
`else
  // Lowest index wins, matching the legacy ifu-first arbiter.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = NUM_MASTERS-1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found)
        grant_idx <= winner;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:    if (found) state_nxt = s_ar_valid[winner] ? RD_ADDR : WR_ADDR;
      RD_ADDR: if (s_ar_valid[grant_idx] && m_ar_ready) state_nxt = RD_DATA;
      RD_DATA: if (m_r_valid && s_r_ready[grant_idx] && m_r_last) begin
                 state_nxt = IDLE;
                 done      = 1'b1;
               end
      WR_ADDR: if (s_aw_valid[grant_idx] && m_aw_ready) state_nxt = WR_DATA;
      WR_DATA: if (s_w_valid[grant_idx] && m_w_ready && s_w_last[grant_idx]) state_nxt = WR_RESP;
      WR_RESP: if (m_b_valid && s_b_ready[grant_idx]) begin
                 state_nxt = IDLE;
                 done      = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ar_valid = 1'b0;
    m_aw_valid = 1'b0;
    m_w_valid  = 1'b0;
    m_w_last   = 1'b0;
    m_r_ready  = 1'b0;
    m_b_ready  = 1'b0;
    s_ar_ready = '0;
    s_aw_ready = '0;
    s_w_ready  = '0;
    s_r_valid  = '0;
    s_b_valid  = '0;
    case (state)
      RD_ADDR: begin
        m_ar_valid            = s_ar_valid[grant_idx];
        s_ar_ready[grant_idx] = m_ar_ready;
      end
      RD_DATA: begin
        s_r_valid[grant_idx] = m_r_valid;
        m_r_ready            = s_r_ready[grant_idx];
      end
      WR_ADDR: begin
        m_aw_valid            = s_aw_valid[grant_idx];
        s_aw_ready[grant_idx] = m_aw_ready;
      end
      WR_DATA: begin
        m_w_valid            = s_w_valid[grant_idx];
        m_w_last             = s_w_last[grant_idx];
        s_w_ready[grant_idx] = m_w_ready;
      end
      WR_RESP: begin
        s_b_valid[grant_idx] = m_b_valid;
        m_b_ready            = s_b_ready[grant_idx];
      end
      default: ;
    endcase
  end

  assign m_ar_addr  = ar_addr_a[grant_idx];
  assign m_ar_id    = ar_id_a[grant_idx];
  assign m_ar_len   = ar_len_a[grant_idx];
  assign m_ar_size  = ar_size_a[grant_idx];
  assign m_ar_burst = ar_burst_a[grant_idx];
  assign m_aw_addr  = aw_addr_a[grant_idx];
  assign m_aw_id    = aw_id_a[grant_idx];
  assign m_aw_len   = aw_len_a[grant_idx];
  assign m_aw_size  = aw_size_a[grant_idx];
  assign m_aw_burst = aw_burst_a[grant_idx];
  assign m_w_data   = w_data_a[grant_idx];
  assign m_w_strb   = w_strb_a[grant_idx];

  // Response buses are shared; only the granted s_*_valid qualifies them.
  assign s_r_data = m_r_data;
  assign s_r_resp = m_r_resp;
  assign s_r_last = m_r_last;
  assign s_r_id   = m_r_id;
  assign s_b_resp = m_b_resp;
  assign s_b_id   = m_b_id;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22040632_axi_rr_arbiter.sv
// tb/tb_ysyx_22040632_axi_rr_arbiter.sv - directed bench for the 4-master AXI arbiter
module tb_ysyx_22040632_axi_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int XW = 2;
`ifdef YSYX_22040632_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rrst_n;
  logic [NM-1:0]      s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [NM*AW-1:0]   s_ar_addr, s_aw_addr;
  logic [NM*IW-1:0]   s_ar_id, s_aw_id;
  logic [NM*8-1:0]    s_ar_len, s_aw_len;
  logic [NM*3-1:0]    s_ar_size, s_aw_size;
  logic [NM*2-1:0]    s_ar_burst, s_aw_burst;
  logic [DW-1:0]      s_r_data;
  logic [1:0]         s_r_resp, s_b_resp;
  logic               s_r_last;
  logic [IW-1:0]      s_r_id, s_b_id;
  logic [NM-1:0]      s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_w_last, s_b_valid, s_b_ready;
  logic [NM*DW-1:0]   s_w_data;
  logic [NM*DW/8-1:0] s_w_strb;
  logic               m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
  logic [AW-1:0]      m_ar_addr, m_aw_addr;
  logic [IW-1:0]      m_ar_id, m_aw_id, m_r_id, m_b_id;
  logic [7:0]         m_ar_len, m_aw_len;
  logic [2:0]         m_ar_size, m_aw_size;
  logic [1:0]         m_ar_burst, m_aw_burst, m_r_resp, m_b_resp;
  logic [DW-1:0]      m_r_data, m_w_data;
  logic               m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last, m_b_valid, m_b_ready;
  logic [DW/8-1:0]    m_w_strb;
  logic [XW-1:0]      grant_idx;
  logic               busy;

  int total = 0;
  int bad = 0;
  logic [XW-1:0] exp_g;

  ysyx_22040632_axi_rr_arbiter #(.NUM_MASTERS(NM), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
                                 .AXI_ID_WIDTH(IW), .IDX_W(XW)) dut (
    .clk(clk), .rrst_n(rrst_n),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .s_r_last(s_r_last), .s_r_id(s_r_id),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp), .s_b_id(s_b_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_r_last(m_r_last), .m_r_id(m_r_id),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp), .m_b_id(m_b_id),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rrst_n = 1'b0;
    s_ar_valid = '0; s_aw_valid = '0; s_w_valid = '0; s_w_last = '0;
    s_r_ready = '0; s_b_ready = '0;
    s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0; s_ar_size = '0; s_ar_burst = '0;
    s_aw_addr = '0; s_aw_id = '0; s_aw_len = '0; s_aw_size = '0; s_aw_burst = '0;
    s_w_data = '0; s_w_strb = '0;
    m_ar_ready = 0; m_aw_ready = 0; m_w_ready = 0; m_r_valid = 0; m_b_valid = 0;
    m_r_data = '0; m_r_resp = '0; m_r_last = 0; m_r_id = '0; m_b_resp = '0; m_b_id = '0;
    for (int k = 0; k < NM; k++) s_ar_addr[k*AW +: AW] = 32'h1000 * k;

    // Reset with every master requesting a read
    s_ar_valid = 4'hF;
    repeat (3) cyc();
    chk("rst_m_ar_valid", m_ar_valid, 1'b0);
    chk("rst_m_aw_valid", m_aw_valid, 1'b0);
    chk("rst_s_ar_ready", s_ar_ready, 4'h0);
    chk("rst_s_r_valid", s_r_valid, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_idx, 2'd0);
    rrst_n = 1'b1;
    #1;
    chk("idle_m_ar_valid", m_ar_valid, 1'b0);
    cyc();
    chk("arb_m_ar_valid", m_ar_valid, 1'b1);
    chk("arb_busy", busy, 1'b1);

    // Fairness: all four hold single-beat reads
    for (int k = 0; k < 5; k++) begin
      exp_g = RR ? 2'(k % 4) : 2'd0;
      chk("fair_grant", grant_idx, exp_g);
      chk("fair_ar_addr", m_ar_addr, 32'h1000 * exp_g);
      m_ar_ready = 1;
      #1;
      chk("fair_s_ar_ready", s_ar_ready, 4'b1 << exp_g);
      cyc();
      m_ar_ready = 0; m_r_valid = 1; m_r_last = 1; m_r_data = 64'(k + 16); s_r_ready = 4'hF;
      #1;
      chk("fair_s_r_valid", s_r_valid, 4'b1 << exp_g);
      chk("fair_s_ar_ready_rd", s_ar_ready, 4'h0);
      chk("fair_s_r_data", s_r_data, 64'(k + 16));
      if (k == 4) s_ar_valid = '0;
      cyc();
      m_r_valid = 0; m_r_last = 0;
      #1;
      chk("fair_idle_busy", busy, 1'b0);
      chk("fair_idle_m_ar_valid", m_ar_valid, 1'b0);
      if (k < 4) cyc();
    end

    // Read burst from master 2, with 5 cycles of backpressure on beat 1
    s_ar_valid = 4'b0100;
    s_ar_addr[2*AW +: AW] = 32'h8000_0040; s_ar_len[2*8 +: 8] = 8'd3; s_ar_id[2*IW +: IW] = 4'd5;
    s_ar_size[2*3 +: 3] = 3'd3; s_ar_burst[2*2 +: 2] = 2'd1;
    cyc();
    chk("rd_grant", grant_idx, 2'd2);
    chk("rd_m_ar_valid", m_ar_valid, 1'b1);
    chk("rd_m_ar_addr", m_ar_addr, 32'h8000_0040);
    chk("rd_m_ar_len", m_ar_len, 8'd3);
    chk("rd_m_ar_id", m_ar_id, 4'd5);
    chk("rd_m_ar_burst", m_ar_burst, 2'd1);
    chk("rd_s_ar_ready_wait", s_ar_ready, 4'h0);
    m_ar_ready = 1;
    #1;
    chk("rd_s_ar_ready", s_ar_ready, 4'b0100);
    cyc();
    s_ar_valid = '0; m_ar_ready = 0; m_r_id = 4'd5; m_r_valid = 1;
    for (int b = 0; b < 4; b++) begin
      m_r_data = 64'hA0 + 64'(b); m_r_last = (b == 3);
      if (b == 1) begin
        s_r_ready = 4'b1011;
        for (int w = 0; w < 5; w++) begin
          #1;
          chk("bp_m_r_ready", m_r_ready, 1'b0);
          chk("bp_s_r_valid", s_r_valid, 4'b0100);
          chk("bp_s_r_data", s_r_data, 64'hA1);
          cyc();
        end
      end
      s_r_ready = 4'b0100;
      #1;
      chk("rd_beat_valid", s_r_valid, 4'b0100);
      chk("rd_beat_data", s_r_data, 64'hA0 + 64'(b));
      chk("rd_beat_id", s_r_id, 4'd5);
      chk("rd_beat_m_r_ready", m_r_ready, 1'b1);
      cyc();
    end
    m_r_valid = 0; m_r_last = 0;
    #1;
    chk("rd_done_busy", busy, 1'b0);
    chk("rd_done_s_r_valid", s_r_valid, 4'h0);

    // Pointer after master 2 completes is 3
    s_ar_valid = 4'b1001;
    cyc();
    exp_g = RR ? 2'd3 : 2'd0;
    chk("ptr_grant", grant_idx, exp_g);
    m_ar_ready = 1;
    cyc();
    s_ar_valid = '0; m_ar_ready = 0; m_r_valid = 1; m_r_last = 1; s_r_ready = 4'hF;
    cyc();
    m_r_valid = 0; m_r_last = 0;

    // Write: master 1, two beats
    s_aw_valid = 4'b0010; s_aw_addr[1*AW +: AW] = 32'h8000_1000; s_aw_len[1*8 +: 8] = 8'd1;
    s_w_valid = 4'b0010; s_w_strb[1*8 +: 8] = 8'hFF; s_w_data[1*DW +: DW] = 64'h1111_1111_1111_1111;
    cyc();
    chk("wr_grant", grant_idx, 2'd1);
    chk("wr_m_aw_valid", m_aw_valid, 1'b1);
    chk("wr_m_aw_addr", m_aw_addr, 32'h8000_1000);
    chk("wr_m_aw_len", m_aw_len, 8'd1);
    chk("wr_m_ar_valid", m_ar_valid, 1'b0);
    chk("wr_m_w_valid_addr", m_w_valid, 1'b0);
    m_aw_ready = 1;
    #1;
    chk("wr_s_aw_ready", s_aw_ready, 4'b0010);
    cyc();
    s_aw_valid = '0; m_aw_ready = 0; m_w_ready = 1;
    #1;
    chk("wr_b0_valid", m_w_valid, 1'b1);
    chk("wr_b0_data", m_w_data, 64'h1111_1111_1111_1111);
    chk("wr_b0_strb", m_w_strb, 8'hFF);
    chk("wr_b0_last", m_w_last, 1'b0);
    chk("wr_b0_s_w_ready", s_w_ready, 4'b0010);
    cyc();
    s_w_data[1*DW +: DW] = 64'h2222_2222_2222_2222; s_w_last = 4'b0010;
    #1;
    chk("wr_b1_data", m_w_data, 64'h2222_2222_2222_2222);
    chk("wr_b1_last", m_w_last, 1'b1);
    cyc();
    s_w_valid = '0; s_w_last = '0; m_w_ready = 0;
    m_b_valid = 1; m_b_resp = 2'd0; m_b_id = 4'd7; s_b_ready = 4'b0010;
    #1;
    chk("wr_m_w_valid_resp", m_w_valid, 1'b0);
    chk("wr_s_b_valid", s_b_valid, 4'b0010);
    chk("wr_s_b_resp", s_b_resp, 2'd0);
    chk("wr_m_b_ready", m_b_ready, 1'b1);
    cyc();
    m_b_valid = 0;
    #1;
    chk("wr_done_busy", busy, 1'b0);
    chk("wr_done_s_b_valid", s_b_valid, 4'h0);

    // Same master raises AR and AW together: read first
    s_ar_valid = 4'b0001; s_aw_valid = 4'b0001; s_aw_addr[0 +: AW] = 32'h8000_2000;
    s_ar_addr[0 +: AW] = 32'h8000_3000;
    cyc();
    chk("ss_grant", grant_idx, 2'd0);
    chk("ss_m_ar_valid", m_ar_valid, 1'b1);
    chk("ss_m_aw_valid_rd", m_aw_valid, 1'b0);
    m_ar_ready = 1;
    cyc();
    s_ar_valid = '0; m_ar_ready = 0; m_r_valid = 1; m_r_last = 1; s_r_ready = 4'b0001;
    #1;
    chk("ss_s_r_valid", s_r_valid, 4'b0001);
    cyc();
    m_r_valid = 0; m_r_last = 0;
    #1;
    chk("ss_idle_m_aw_valid", m_aw_valid, 1'b0);
    cyc();
    chk("ss_wr_m_aw_valid", m_aw_valid, 1'b1);
    chk("ss_wr_m_aw_addr", m_aw_addr, 32'h8000_2000);
    chk("ss_wr_grant", grant_idx, 2'd0);
    m_aw_ready = 1;
    cyc();
    s_aw_valid = '0; m_aw_ready = 0; s_w_valid = 4'b0001; s_w_last = 4'b0001; m_w_ready = 1;
    cyc();
    s_w_valid = '0; s_w_last = '0; m_w_ready = 0; m_b_valid = 1; s_b_ready = 4'b0001;
    #1;
    chk("ss_s_b_valid", s_b_valid, 4'b0001);
    cyc();
    m_b_valid = 0;
    #1;
    chk("ss_done_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
